// File: rtl/sd_block_responder.sv
// Target end of the virtual SD block interface: acknowledges one block request at a time
// and copies a 2^BLK_AW-byte block between a backing byte memory and the requester's buffer.
module sd_block_responder #(
  parameter int VDNUM     = 2,
  parameter int ACK_DELAY = 4,
  parameter int BLK_AW    = 9
) (
  input  logic              CLK_VIDEO,
  input  logic              reset,
  input  logic [31:0]       sd_lba_0,
  input  logic [31:0]       sd_lba_1,
  input  logic [VDNUM-1:0]  sd_rd,
  input  logic [VDNUM-1:0]  sd_wr,
  output logic [VDNUM-1:0]  sd_ack,
  output logic [BLK_AW-1:0] sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din_0,
  input  logic [7:0]        sd_buff_din_1,
  input  logic [31:0]       img_blocks_0,
  input  logic [31:0]       img_blocks_1,
  output logic [31:0]       mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int DW = (VDNUM > 1) ? $clog2(VDNUM) : 1;
  localparam int OW = BLK_AW + 1;
  localparam logic [7:0]    CNT_LAST = 8'(ACK_DELAY - 1);
  localparam logic [OW-1:0] LAST_OFF = OW'((1 << BLK_AW) - 1);

  typedef enum logic [3:0] {
    IDLE, ACK_WAIT, RD_FETCH, RD_PUT,
    WR_ADDR, WR_WAIT, WR_CAPT, WR_STORE,
    FINISH, GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     drv_reg, drv_next;
  logic              dir_rd_reg, dir_rd_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [31:0]       lba_reg, lba_next;
  logic              err_reg, err_next;
  logic [OW-1:0]     off_reg, off_next;
  logic [VDNUM-1:0]  ack_reg, ack_next;
  logic [BLK_AW-1:0] buff_addr_reg, buff_addr_next;
  logic [7:0]        dout_reg, dout_next;
  logic              buff_wr_reg, buff_wr_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              mem_wr_reg, mem_wr_next;
  logic [7:0]        wdata_reg, wdata_next;

  logic [VDNUM-1:0]  req;
  logic [DW-1:0]     req_idx;
  logic              req_any;
  logic [31:0]       cur_lba;
  logic [31:0]       cur_img;
  logic [7:0]        cur_din;
  logic              out_of_range;
  logic              last_byte;

  assign req          = sd_rd | sd_wr;
  assign cur_lba      = (drv_reg == '0) ? sd_lba_0 : sd_lba_1;
  assign cur_img      = (drv_reg == '0) ? img_blocks_0 : img_blocks_1;
  assign cur_din      = (drv_reg == '0) ? sd_buff_din_0 : sd_buff_din_1;
  assign out_of_range = (cur_lba >= cur_img);
  assign last_byte    = (off_reg == LAST_OFF);

  // Lowest-numbered requesting drive wins.
  always_comb begin
    req_idx = '0;
    req_any = 1'b0;
    for (int i = VDNUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        req_idx = DW'(i);
        req_any = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_reg     <= IDLE;
      drv_reg       <= '0;
      dir_rd_reg    <= 1'b0;
      cnt_reg       <= '0;
      lba_reg       <= '0;
      err_reg       <= 1'b0;
      off_reg       <= '0;
      ack_reg       <= '0;
      buff_addr_reg <= '0;
      dout_reg      <= '0;
      buff_wr_reg   <= 1'b0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      drv_reg       <= drv_next;
      dir_rd_reg    <= dir_rd_next;
      cnt_reg       <= cnt_next;
      lba_reg       <= lba_next;
      err_reg       <= err_next;
      off_reg       <= off_next;
      ack_reg       <= ack_next;
      buff_addr_reg <= buff_addr_next;
      dout_reg      <= dout_next;
      buff_wr_reg   <= buff_wr_next;
      mem_rd_reg    <= mem_rd_next;
      mem_wr_reg    <= mem_wr_next;
      wdata_reg     <= wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drv_next       = drv_reg;
    dir_rd_next    = dir_rd_reg;
    cnt_next       = cnt_reg;
    lba_next       = lba_reg;
    err_next       = err_reg;
    off_next       = off_reg;
    ack_next       = ack_reg;
    buff_addr_next = buff_addr_reg;
    dout_next      = dout_reg;
    buff_wr_next   = 1'b0;
    mem_rd_next    = mem_rd_reg;
    mem_wr_next    = mem_wr_reg;
    wdata_next     = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          drv_next    = req_idx;
          dir_rd_next = sd_rd[req_idx];
          cnt_next    = '0;
          state_next  = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (cnt_reg == CNT_LAST) begin
          // Requester bumps its lba on this ack edge, so this captures the pre-increment value.
          ack_next = VDNUM'(1) << drv_reg;
          lba_next = cur_lba;
          err_next = out_of_range;
          off_next = '0;
          if (dir_rd_reg) begin
            mem_rd_next = !out_of_range;
            state_next  = RD_FETCH;
          end else begin
            buff_addr_next = '0;
            state_next     = WR_ADDR;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RD_FETCH: begin
        if (err_reg || mem_ack) begin
          mem_rd_next    = 1'b0;
          dout_next      = err_reg ? 8'h00 : mem_rdata;
          buff_addr_next = off_reg[BLK_AW-1:0];
          buff_wr_next   = 1'b1;
          state_next     = RD_PUT;
        end
      end
      RD_PUT: begin
        if (last_byte) begin
          ack_next   = '0;
          state_next = FINISH;
        end else begin
          off_next    = off_reg + 1'b1;
          mem_rd_next = !err_reg;
          state_next  = RD_FETCH;
        end
      end
      WR_ADDR:  state_next = WR_WAIT;
      // Requester buffer has one cycle of read latency; WR_WAIT covers it.
      WR_WAIT:  state_next = WR_CAPT;
      WR_CAPT: begin
        wdata_next  = cur_din;
        mem_wr_next = !err_reg;
        state_next  = WR_STORE;
      end
      WR_STORE: begin
        if (err_reg || mem_ack) begin
          mem_wr_next = 1'b0;
          if (last_byte) begin
            ack_next   = '0;
            state_next = FINISH;
          end else begin
            off_next       = off_reg + 1'b1;
            buff_addr_next = off_reg[BLK_AW-1:0] + 1'b1;
            state_next     = WR_ADDR;
          end
        end
      end
      FINISH: begin
        cnt_next   = '0;
        state_next = GAP;
      end
      GAP: begin
        if (cnt_reg == CNT_LAST) state_next = IDLE;
        else                     cnt_next   = cnt_reg + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sd_ack       = ack_reg;
  assign sd_buff_addr = buff_addr_reg;
  assign sd_buff_dout = dout_reg;
  assign sd_buff_wr   = buff_wr_reg;
  // {drive, lba, offset} keeps only its low 32 bits.
  assign mem_addr     = 32'({drv_reg[0], lba_reg, off_reg[BLK_AW-1:0]});
  assign mem_rd       = mem_rd_reg;
  assign mem_wr       = mem_wr_reg;
  assign mem_wdata    = wdata_reg;
  assign busy         = (state_reg != IDLE);
  assign err          = err_reg;

endmodule

// File: tb/tb_sd_block_responder.sv
// Randomized scoreboard bench for sd_block_responder: expected buffer strobes and memory
// writes are queued from a block-level model; a monitor pops them as the DUT produces them.
module tb_sd_block_responder;
  localparam int ACK_DELAY = 4;
  localparam int BLK_AW    = 9;
  localparam int BLK       = 1 << BLK_AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sd_lba_0 = '0, sd_lba_1 = '0;
  logic [31:0] img_blocks_0 = '0, img_blocks_1 = '0;
  logic [1:0]  sd_rd = '0, sd_wr = '0;
  logic [1:0]  sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din_0, sd_buff_din_1;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int access_cyc = 0;
  int rise_cnt [2];
  int rise_cyc [2];
  int fall_cyc [2];
  logic late_ack_req = 1'b0;

  logic [7:0]  mem_model [logic [31:0]];
  logic [7:0]  buf0 [BLK];
  logic [7:0]  buf1 [BLK];
  logic [16:0] exp_rd [$];
  logic [39:0] exp_wr [$];

  sd_block_responder #(.VDNUM(2), .ACK_DELAY(ACK_DELAY), .BLK_AW(BLK_AW)) dut (
    .CLK_VIDEO(clk), .reset(reset),
    .sd_lba_0(sd_lba_0), .sd_lba_1(sd_lba_1),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din_0(sd_buff_din_0), .sd_buff_din_1(sd_buff_din_1),
    .img_blocks_0(img_blocks_0), .img_blocks_1(img_blocks_1),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Requester sector buffers with registered read.
  always @(posedge clk) begin
    sd_buff_din_0 <= buf0[sd_buff_addr];
    sd_buff_din_1 <= buf1[sd_buff_addr];
  end

  function automatic logic [31:0] byte_addr(input int d, input logic [31:0] lba, input int k);
    logic [63:0] full;
    full = (64'(d) << (32 + BLK_AW)) + (64'(lba) << BLK_AW) + 64'(k);
    return full[31:0];
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[16:9] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_read(input int d, input logic [31:0] lba, input logic [31:0] img);
    for (int k = 0; k < BLK; k++)
      exp_rd.push_back({9'(k), (lba >= img) ? 8'h00 : mem_byte(byte_addr(d, lba, k))});
  endtask

  task automatic push_write(input int d, input logic [31:0] lba, input logic [31:0] img);
    if (lba < img)
      for (int k = 0; k < BLK; k++)
        exp_wr.push_back({byte_addr(d, lba, k), (d == 0) ? buf0[k] : buf1[k]});
  endtask

  // Requester side: each drive drops its request once acknowledged; run until quiet.
  task automatic serve(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      for (int d = 0; d < 2; d++)
        if (sd_ack[d]) begin sd_rd[d] = 1'b0; sd_wr[d] = 1'b0; end
    end while ((busy || sd_rd != 2'b00 || sd_wr != 2'b00) && n < max_cyc);
    check("serve_timeout", longint'(n >= max_cyc), 0);
  endtask

  // Monitor + memory responder.
  initial begin : monitor
    logic [1:0]  ack_prev;
    logic [16:0] e;
    logic [39:0] w;
    int          wait_cnt;
    ack_prev = '0; wait_cnt = 0; mem_ack = 1'b0; mem_rdata = '0;
    for (int d = 0; d < 2; d++) begin rise_cnt[d] = 0; rise_cyc[d] = 0; fall_cyc[d] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      checks++;
      if ($countones(sd_ack) > 1) begin
        errors++;
        $display("FAIL ack_onehot: sd_ack=%b required at most one bit", sd_ack);
      end
      for (int d = 0; d < 2; d++) begin
        if (sd_ack[d] && !ack_prev[d]) begin rise_cnt[d]++; rise_cyc[d] = cyc; end
        if (!sd_ack[d] && ack_prev[d]) fall_cyc[d] = cyc;
      end
      ack_prev = sd_ack;
      if (sd_buff_wr) begin
        strobe_cnt++;
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: addr=%0d dout=%02h required no strobe", sd_buff_addr, sd_buff_dout);
        end else begin
          e = exp_rd.pop_front();
          if ({sd_buff_addr, sd_buff_dout} !== e) begin
            errors++;
            $display("FAIL buff_strobe: addr=%0d dout=%02h required addr=%0d dout=%02h",
                     sd_buff_addr, sd_buff_dout, e[16:8], e[7:0]);
          end
        end
      end
      if (mem_rd || mem_wr) access_cyc++;
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_rd || mem_wr) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          checks++;
          if (err) begin
            errors++;
            $display("FAIL mem_while_err: rd=%0b wr=%0b required no access", mem_rd, mem_wr);
          end
          if (mem_rd) mem_rdata = mem_byte(mem_addr);
          else begin
            checks++;
            if (exp_wr.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write: addr=%08h data=%02h", mem_addr, mem_wdata);
            end else begin
              w = exp_wr.pop_front();
              if ({mem_addr, mem_wdata} !== w) begin
                errors++;
                $display("FAIL mem_write: addr=%08h data=%02h required addr=%08h data=%02h",
                         mem_addr, mem_wdata, w[39:8], w[7:0]);
              end
            end
            mem_model[mem_addr] = mem_wdata;
          end
          mem_ack  = 1'b1;
          wait_cnt = $urandom_range(0, 1);
        end
      end else if (late_ack_req) mem_ack = 1'b1;
    end
  end

  initial begin : stimulus
    int n, s0, r0, r1, a0, acks, mism;
    int unsigned d, rd, both, img, lba;
    logic ackp;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ack", longint'(sd_ack), 0);
    check("rst_addr", longint'(sd_buff_addr), 0);
    check("rst_dout", longint'(sd_buff_dout), 0);
    check("rst_bwr", longint'(sd_buff_wr), 0);
    check("rst_maddr", longint'(mem_addr), 0);
    check("rst_mrd", longint'(mem_rd), 0);
    check("rst_mwr", longint'(mem_wr), 0);
    check("rst_wdata", longint'(mem_wdata), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_err", longint'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    // Read, drive 1, block 7 holds k[7:0]
    img_blocks_1 = 100; sd_lba_1 = 7;
    for (int k = 0; k < BLK; k++) mem_model[byte_addr(1, 7, k)] = 8'(k);
    push_read(1, 7, 100);
    r1 = rise_cnt[1]; s0 = strobe_cnt;
    sd_rd[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!sd_ack[1] && n < 50);
    // Request seen on the first edge, ack ACK_DELAY edges later.
    check("ack_latency", n, ACK_DELAY + 1);
    sd_rd[1] = 1'b0;
    serve(8000);
    check("rd1_strobes", strobe_cnt - s0, BLK);
    check("rd1_queue", exp_rd.size(), 0);
    check("rd1_acks", rise_cnt[1] - r1, 1);
    check("rd1_err", longint'(err), 0);
    check("rd1_busy", longint'(busy), 0);
    $display("txn read drive=1 lba=7 strobes=%0d", strobe_cnt - s0);

    // Write, drive 0, block 3
    img_blocks_0 = 64; sd_lba_0 = 3;
    for (int k = 0; k < BLK; k++) buf0[k] = 8'hA5 ^ 8'(k);
    push_write(0, 3, 64);
    s0 = strobe_cnt;
    sd_wr[0] = 1'b1;
    serve(8000);
    mism = 0;
    for (int k = 0; k < BLK; k++) if (mem_byte(byte_addr(0, 3, k)) != (8'hA5 ^ 8'(k))) mism++;
    check("wr0_mem", mism, 0);
    check("wr0_queue", exp_wr.size(), 0);
    check("wr0_no_strobe", strobe_cnt - s0, 0);
    $display("txn write drive=0 lba=3 mismatched_bytes=%0d", mism);

    // Multi-block streaming: blocks 13..25 with sd_rd[0] held
    sd_lba_0 = 13;
    for (int b = 13; b < 26; b++) push_read(0, b, 64);
    r0 = rise_cnt[0]; acks = 0; ackp = 1'b0; n = 0;
    sd_rd[0] = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (sd_ack[0] && !ackp) begin
        acks++;
        sd_lba_0 = sd_lba_0 + 1;
        if (acks == 13) sd_rd[0] = 1'b0;
      end
      ackp = sd_ack[0];
    end while ((busy || sd_rd[0]) && n < 60000);
    check("multi_timeout", longint'(n >= 60000), 0);
    repeat (20) @(negedge clk);
    check("multi_acks", rise_cnt[0] - r0, 13);
    check("multi_queue", exp_rd.size(), 0);
    $display("txn multi drive=0 lba=13..25 acks=%0d", rise_cnt[0] - r0);

    // Arbitration: both drives request together
    sd_lba_0 = 30; sd_lba_1 = 40;
    push_read(0, 30, 64); push_read(1, 40, 100);
    r0 = rise_cnt[0]; r1 = rise_cnt[1];
    sd_rd = 2'b11;
    serve(16000);
    check("arb_acks0", rise_cnt[0] - r0, 1);
    check("arb_acks1", rise_cnt[1] - r1, 1);
    check("arb_order", longint'(rise_cyc[0] < rise_cyc[1]), 1);
    check("arb_gap", longint'(rise_cyc[1] - fall_cyc[0] > ACK_DELAY), 1);
    check("arb_queue", exp_rd.size(), 0);
    $display("txn arb drive0 rise=%0d fall=%0d drive1 rise=%0d", rise_cyc[0], fall_cyc[0], rise_cyc[1]);

    // Out of range read
    img_blocks_0 = 50; sd_lba_0 = 50;
    push_read(0, 50, 50);
    a0 = access_cyc;
    sd_rd[0] = 1'b1;
    serve(8000);
    check("oor_err", longint'(err), 1);
    check("oor_no_mem", access_cyc - a0, 0);
    check("oor_queue", exp_rd.size(), 0);
    $display("txn read drive=0 lba=50 img=50 err=%0b", err);

    // Randomized transactions
    for (int t = 0; t < 5; t++) begin
      d = $urandom_range(0, 1); rd = $urandom_range(0, 1); both = ($urandom_range(0, 3) == 0);
      img = $urandom_range(0, 40); lba = $urandom_range(0, 48);
      if (d == 0) begin img_blocks_0 = img; sd_lba_0 = lba; end
      else        begin img_blocks_1 = img; sd_lba_1 = lba; end
      if (rd != 0) push_read(int'(d), lba, img);
      else begin
        for (int k = 0; k < BLK; k++) begin
          if (d == 0) buf0[k] = 8'($urandom); else buf1[k] = 8'($urandom);
        end
        push_write(int'(d), lba, img);
      end
      if (rd != 0) begin sd_rd[d] = 1'b1; if (both != 0) sd_wr[d] = 1'b1; end
      else sd_wr[d] = 1'b1;
      serve(8000);
      check("rnd_err", longint'(err), longint'(lba >= img));
      check("rnd_rdq", exp_rd.size(), 0);
      check("rnd_wrq", exp_wr.size(), 0);
      $display("txn rnd%0d drive=%0d %s lba=%0d img=%0d err=%0b", t, d,
               (rd != 0) ? ((both != 0) ? "rd+wr" : "read") : "write", lba, img, err);
    end

    // Reset in the middle of a read, then a clean retry
    img_blocks_1 = 100; sd_lba_1 = 9;
    push_read(1, 9, 100);
    s0 = strobe_cnt; n = 0;
    sd_rd[1] = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (sd_ack[1]) sd_rd[1] = 1'b0;
    end while (strobe_cnt - s0 < 200 && n < 5000);
    reset = 1'b1; sd_rd = 2'b00;
    @(negedge clk);
    check("rst_mid_ack", longint'(sd_ack), 0);
    check("rst_mid_mrd", longint'(mem_rd), 0);
    check("rst_mid_busy", longint'(busy), 0);
    reset = 1'b0;
    exp_rd.delete();
    s0 = strobe_cnt;
    late_ack_req = 1'b1;
    repeat (2) @(negedge clk);
    late_ack_req = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_busy", longint'(busy), 0);
    check("late_ack_strobes", strobe_cnt - s0, 0);
    push_read(1, 9, 100);
    sd_rd[1] = 1'b1;
    serve(8000);
    check("retry_strobes", strobe_cnt - s0, BLK);
    check("retry_queue", exp_rd.size(), 0);
    $display("txn retry drive=1 lba=9 strobes=%0d", strobe_cnt - s0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Target end of the MiSTer-style virtual SD block interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) used by the emu floppy and HDD request logic.
- Answers each block request by asserting sd_ack, then moving one 512-byte block between a backing byte memory and the requester's sector buffer.
- Lets Verilator benches run disk traffic entirely in RTL, with no C++ SD model.

Parameters:
- VDNUM, 2, number of virtual drives (request lines); drive 0 has highest priority.
- ACK_DELAY, 4, idle cycles between seeing a request and asserting sd_ack; also the minimum gap after sd_ack falls (range 1..255).
- BLK_AW, 9, buffer address width; block size is 2^BLK_AW bytes.

Ports:
- CLK_VIDEO  in  1  clock.
- reset  in  1  synchronous, active-high.
- sd_lba_0  in  32  block number for drive 0.
- sd_lba_1  in  32  block number for drive 1.
- sd_rd  in  VDNUM  read request, one bit per drive.
- sd_wr  in  VDNUM  write request, one bit per drive.
- sd_ack  out  VDNUM  transfer-in-progress, one-hot or zero.
- sd_buff_addr  out  BLK_AW  byte index in the block.
- sd_buff_dout  out  8  read data to the requester.
- sd_buff_wr  out  1  one-cycle strobe: requester writes sd_buff_dout at sd_buff_addr.
- sd_buff_din_0  in  8  drive-0 buffer data (registered, 1-cycle read latency).
- sd_buff_din_1  in  8  drive-1 buffer data (registered, 1-cycle read latency).
- img_blocks_0  in  32  image size in blocks, drive 0; 0 means unmounted.
- img_blocks_1  in  32  image size in blocks, drive 1; 0 means unmounted.
- mem_addr  out  32  byte address = {drive bit, lba, offset}, truncated to 32 bits.
- mem_rd  out  1  read request; held until mem_ack.
- mem_wr  out  1  write request; held until mem_ack.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle access-complete strobe.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  current or last request was out of range.

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-transfer abandons the transfer at once: sd_ack drops and mem_rd/mem_wr drop without waiting for mem_ack. A late mem_ack after reset is ignored.
- IDLE:
  - Arbitrate the lowest drive index n with sd_rd[n]|sd_wr[n]. If both are set for that drive, read wins.
  - Latch n and the direction, go to ACK_WAIT.
- ACK_WAIT:
  - Count ACK_DELAY cycles, then assert sd_ack[n].
  - In that same edge, latch lba = sd_lba_n. The requester increments its lba on the ack rising edge, so the pre-increment value is the one captured.
  - Set err = (lba >= img_blocks_n), evaluated once per request. err holds until the next request is latched.
  - Go to RD_FETCH or WR_ADDR with offset i = 0.
  - A request that drops during ACK_WAIT is still served.
- Read path:
  - RD_FETCH: assert mem_rd with mem_addr = base + i; wait for mem_ack, capture mem_rdata. If err, skip memory and use 0x00.
  - RD_PUT: for exactly one cycle drive sd_buff_addr = i, sd_buff_dout = data, sd_buff_wr = 1.
  - If i = 2^BLK_AW-1 go to FINISH, else i++ and return to RD_FETCH.
  - Minimum 2 cycles per byte.
- Write path:
  - WR_ADDR: drive sd_buff_addr = i.
  - WR_WAIT: one cycle.
  - WR_CAPT: sample sd_buff_din_n into mem_wdata.
  - WR_STORE: assert mem_wr until mem_ack. If err, skip memory and discard the byte.
  - Last byte goes to FINISH, otherwise i++ and return to WR_ADDR.
  - sd_buff_wr stays 0 throughout a write.
- FINISH:
  - Deassert sd_ack (the falling edge signals completion).
  - Hold sd_buff_addr at its last value.
  - Wait ACK_DELAY cycles in GAP, then return to IDLE.
  - A request still high after GAP is served as a new block. This gives multi-block streaming: 13 consecutive sectors with sd_rd held high.
- sd_buff_addr wraps naturally; the offset counter is BLK_AW+1 bits so the last-byte compare is exact.
- Requests on other drives during a transfer wait; they are not lost, since the request lines are level-held by the requester.
- sd_ack is never asserted for two drives at once.

Test Plan:
- Read, drive 1:
  - Stimulus: img_blocks_1 = 100, memory byte k of block 7 = k[7:0], sd_lba_1 = 7, pulse sd_rd[1] high until ack.
  - Response: sd_ack[1] rises 4 cycles after the request; 512 sd_buff_wr strobes with addr 0..511 and dout = addr[7:0]; sd_ack[1] falls; busy returns to 0.
- Write, drive 0:
  - Stimulus: requester buffer holds 0xA5^addr, sd_lba_0 = 3, sd_wr[0] high.
  - Response: memory block 3 (drive 0) equals 0xA5^k for all 512 bytes; no sd_buff_wr pulse occurs.
- Multi-block:
  - Stimulus: sd_rd[0] held high while the requester increments lba on each ack rise, starting at 13, deasserting at the 13th ack.
  - Response: exactly 13 ack pulses; blocks 13..25 are delivered in order.
- Arbitration:
  - Stimulus: sd_rd[0] and sd_rd[1] asserted in the same cycle.
  - Response: drive 0 is served first; drive 1's ack rises only after GAP; at no point are both ack bits set.
- Out of range:
  - Stimulus: sd_lba_0 = 50 with img_blocks_0 = 50.
  - Response: err = 1; 512 bytes of 0x00 delivered; no mem_rd issued.
- Reset mid-read:
  - Stimulus: assert reset at byte 200 of a read.
  - Response: next edge gives sd_ack = 0, mem_rd = 0, busy = 0; a new request is then served cleanly from offset 0.
